// File: rtl/spi_reg_bank.sv
// SPI-addressed register bank: ID, control, sticky status, parameters and a coefficient commit path.
// Define STATUS_CLEAR_ON_READ_EN to make status clear-on-read; otherwise status is write-1-to-clear.
module spi_reg_bank #(
  parameter int           ADDR_BITS = 7,
  parameter int           DATA_BITS = 8,
  parameter logic [7:0]   ID_VALUE  = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] spi_addr,
  input  logic                 spi_write_stb,
  input  logic [DATA_BITS-1:0] spi_write_data,
  input  logic                 spi_read_stb,
  output logic [DATA_BITS-1:0] spi_read_data,
  output logic [7:0]           ctrl,
  output logic [63:0]          param_bus,
  input  logic [5:0]           status_evt,
  output logic                 coef_valid,
  input  logic                 coef_ready,
  output logic [7:0]           coef_addr,
  output logic [23:0]          coef_data
);

  localparam logic [ADDR_BITS-1:0] A_ID     = ADDR_BITS'(8'h00);
  localparam logic [ADDR_BITS-1:0] A_CTRL   = ADDR_BITS'(8'h01);
  localparam logic [ADDR_BITS-1:0] A_STATUS = ADDR_BITS'(8'h02);
  localparam logic [ADDR_BITS-1:0] A_CADDR  = ADDR_BITS'(8'h03);
  localparam logic [ADDR_BITS-1:0] A_STG0   = ADDR_BITS'(8'h10);
  localparam logic [ADDR_BITS-1:0] A_STG1   = ADDR_BITS'(8'h11);
  localparam logic [ADDR_BITS-1:0] A_STG2   = ADDR_BITS'(8'h12);
  localparam logic [ADDR_BITS-1:0] A_COMMIT = ADDR_BITS'(8'h13);

  typedef enum logic {IDLE, PENDING} state_e;

  state_e               state_q, state_d;
  logic [7:0]           ctrl_q, ctrl_d;
  logic [7:0]           caddr_q, caddr_d;
  logic [7:0]           stage0_q, stage0_d, stage1_q, stage1_d, stage2_q, stage2_d;
  logic [63:0]          param_q, param_d;
  logic [5:0]           evt_q, evt_d;
  logic                 ovf_q, ovf_d;
  logic                 coef_valid_q, coef_valid_d;
  logic [7:0]           coef_addr_q, coef_addr_d;
  logic [23:0]          coef_data_q, coef_data_d;
  logic [DATA_BITS-1:0] read_data_q, read_data_d;

  logic [7:0] wdata;
  logic [7:0] rd_val;
  logic       param_hit;
  logic [5:0] evt_clr;
  logic       ovf_clr;
  logic       ovf_set;

  assign wdata     = spi_write_data[7:0];
  assign param_hit = (spi_addr[ADDR_BITS-1:3] == (ADDR_BITS-3)'(4));

  always_comb begin
    rd_val = 8'h00;
    case (spi_addr)
      A_ID:     rd_val = ID_VALUE;
      A_CTRL:   rd_val = ctrl_q;
      A_STATUS: rd_val = {ovf_q, coef_valid_q, evt_q};
      A_CADDR:  rd_val = caddr_q;
      A_STG0:   rd_val = stage0_q;
      A_STG1:   rd_val = stage1_q;
      A_STG2:   rd_val = stage2_q;
      default:  if (param_hit) rd_val = param_q[{spi_addr[2:0], 3'b000} +: 8];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    caddr_d      = caddr_q;
    stage0_d     = stage0_q;
    stage1_d     = stage1_q;
    stage2_d     = stage2_q;
    param_d      = param_q;
    coef_valid_d = coef_valid_q;
    coef_addr_d  = coef_addr_q;
    coef_data_d  = coef_data_q;
    read_data_d  = read_data_q;
    evt_clr      = 6'h00;
    ovf_clr      = 1'b0;
    ovf_set      = 1'b0;

    if (spi_read_stb) begin
      read_data_d = DATA_BITS'(rd_val);
`ifdef STATUS_CLEAR_ON_READ_EN
      if (spi_addr == A_STATUS) begin
        evt_clr = 6'h3F;
        ovf_clr = 1'b1;
      end
`endif
    end

    // Accept is applied before the write decode so a same-cycle write to 0x03 wins.
    if (state_q == PENDING && coef_ready) begin
      coef_valid_d = 1'b0;
      caddr_d      = caddr_q + 8'd1;
      state_d      = IDLE;
    end

    if (spi_write_stb) begin
      case (spi_addr)
        A_CTRL:   ctrl_d = wdata;
        A_STATUS: begin
`ifndef STATUS_CLEAR_ON_READ_EN
          evt_clr = wdata[5:0];
          ovf_clr = wdata[7];
`endif
        end
        A_CADDR:  caddr_d  = wdata;
        A_STG0:   stage0_d = wdata;
        A_STG1:   stage1_d = wdata;
        A_STG2:   stage2_d = wdata;
        A_COMMIT: begin
          if (state_q == IDLE) begin
            coef_data_d  = {stage2_q, stage1_q, stage0_q};
            coef_addr_d  = caddr_q;
            coef_valid_d = 1'b1;
            state_d      = PENDING;
          end else begin
            ovf_set = 1'b1;
          end
        end
        default:  if (param_hit) param_d[{spi_addr[2:0], 3'b000} +: 8] = wdata;
      endcase
    end

    // Sets are OR-ed in after clears so an event wins over a same-cycle clear.
    evt_d = (evt_q & ~evt_clr) | status_evt;
    ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ctrl_q       <= '0;
      caddr_q      <= '0;
      stage0_q     <= '0;
      stage1_q     <= '0;
      stage2_q     <= '0;
      param_q      <= '0;
      evt_q        <= '0;
      ovf_q        <= 1'b0;
      coef_valid_q <= 1'b0;
      coef_addr_q  <= '0;
      coef_data_q  <= '0;
      read_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      caddr_q      <= caddr_d;
      stage0_q     <= stage0_d;
      stage1_q     <= stage1_d;
      stage2_q     <= stage2_d;
      param_q      <= param_d;
      evt_q        <= evt_d;
      ovf_q        <= ovf_d;
      coef_valid_q <= coef_valid_d;
      coef_addr_q  <= coef_addr_d;
      coef_data_q  <= coef_data_d;
      read_data_q  <= read_data_d;
    end
  end

  assign spi_read_data = read_data_q;
  assign ctrl          = ctrl_q;
  assign param_bus     = param_q;
  assign coef_valid    = coef_valid_q;
  assign coef_addr     = coef_addr_q;
  assign coef_data     = coef_data_q;

endmodule
